edit_input_conditioner: RTL and testbench

// - Front end for the alarm-clock CPU's switch and button PIO inputs.
// - Synchronises and debounces the raw board switches and edit buttons.
// - Switches are delivered as clean levels on sw_states.
// - Button presses are delivered on btn_edit as stretched event pulses, with

---
 rtl/edit_input_conditioner.sv | 166 ++++++++++++++++
 tb/tb_edit_input_conditioner.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/edit_input_conditioner.sv
// Switch/button front end for the alarm-clock CPU: 2-FF sync, debounce, and per-button
// press/auto-repeat event generation with pulse stretching.
module edit_input_conditioner #(
  parameter int unsigned N_SW            = 3,
  parameter int unsigned N_BTN           = 2,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned STRETCH_CYCLES  = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_SW-1:0]  sw_states,
  output logic [N_BTN-1:0] btn_edit,
  output logic [N_BTN-1:0] btn_level
);

  localparam int unsigned N_IN    = N_SW + N_BTN;
  localparam int unsigned MAX_RPT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned MAX_DR  = (DEBOUNCE_CYCLES > MAX_RPT) ? DEBOUNCE_CYCLES : MAX_RPT;
  localparam int unsigned MAX_P   = (STRETCH_CYCLES > MAX_DR) ? STRETCH_CYCLES : MAX_DR;
  localparam int unsigned CW      = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE - 1);
  localparam logic [CW-1:0] ST_LOAD = CW'(STRETCH_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Raw pin value of each input when inactive; also the polarity-normalising XOR mask.
  localparam logic [N_IN-1:0] IN_INACTIVE = {{N_BTN{BTN_ACTIVE_LOW}}, {N_SW{1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRpt
  } btn_state_e;

  logic [N_IN-1:0] r_sync1;
  logic [N_IN-1:0] r_sync2;
  logic [N_IN-1:0] w_sync;
  logic [N_IN-1:0] w_deb;
  logic [N_IN-1:0] r_out;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= IN_INACTIVE;
      r_sync2 <= IN_INACTIVE;
    end else begin
      r_sync1 <= {btn_raw, sw_raw};
      r_sync2 <= r_sync1;
    end
  end

  assign w_sync = r_sync2 ^ IN_INACTIVE;

  for (genvar g = 0; g < N_IN; g++) begin : g_deb
    logic [CW-1:0] r_dcnt;
    logic          r_deb;

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_dcnt <= '0;
        r_deb  <= 1'b0;
      end else if (w_sync[g] == r_deb) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DB_LAST) begin
        r_deb  <= w_sync[g];
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + CNT_ONE;
      end
    end

    assign w_deb[g] = r_deb;
  end

  // Output stage keeps level outputs aligned with the stretched event outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out <= '0;
    end else begin
      r_out <= w_deb;
    end
  end

  assign sw_states = r_out[N_SW-1:0];
  assign btn_level = r_out[N_IN-1:N_SW];

  for (genvar b = 0; b < N_BTN; b++) begin : g_btn
    btn_state_e    r_state;
    btn_state_e    w_state_nx;
    logic [CW-1:0] r_rcnt;
    logic [CW-1:0] w_rcnt_nx;
    logic [CW-1:0] r_scnt;
    logic          w_event;
    logic          w_lvl;

    assign w_lvl = w_deb[N_SW + b];

    // Release has priority over a repeat falling on the same cycle.
    always_comb begin
      w_state_nx = r_state;
      w_rcnt_nx  = r_rcnt;
      w_event    = 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_lvl) begin
            w_event    = 1'b1;
            w_rcnt_nx  = '0;
            w_state_nx = StHold;
          end
        end
        StHold: begin
          if (!w_lvl) begin
            w_rcnt_nx  = '0;
            w_state_nx = StIdle;
          end else if (r_rcnt == RD_LAST) begin
            w_event    = 1'b1;
            w_rcnt_nx  = '0;
            w_state_nx = StRpt;
          end else begin
            w_rcnt_nx  = r_rcnt + CNT_ONE;
          end
        end
        StRpt: begin
          if (!w_lvl) begin
            w_rcnt_nx  = '0;
            w_state_nx = StIdle;
          end else if (r_rcnt == RR_LAST) begin
            w_event    = 1'b1;
            w_rcnt_nx  = '0;
          end else begin
            w_rcnt_nx  = r_rcnt + CNT_ONE;
          end
        end
        default: begin
          w_rcnt_nx  = '0;
          w_state_nx = StIdle;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_state <= StIdle;
        r_rcnt  <= '0;
        r_scnt  <= '0;
      end else begin
        r_state <= w_state_nx;
        r_rcnt  <= w_rcnt_nx;
        if (w_event) begin
          r_scnt <= ST_LOAD;
        end else if (r_scnt != '0) begin
          r_scnt <= r_scnt - CNT_ONE;
        end
      end
    end

    assign btn_edit[b] = (r_scnt != '0);
  end

endmodule

// File: tb/tb_edit_input_conditioner.sv
// Directed bench for edit_input_conditioner with short debounce/repeat/stretch parameters.
module tb_edit_input_conditioner;

  logic       clk;
  logic       reset;
  logic [2:0] sw_raw;
  logic [1:0] btn_raw;
  logic [2:0] sw_states;
  logic [1:0] btn_edit;
  logic [1:0] btn_level;

  int errors = 0;
  int checks = 0;

  edit_input_conditioner #(
    .N_SW            (3),
    .N_BTN           (2),
    .BTN_ACTIVE_LOW  (1'b1),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_RATE     (8),
    .STRETCH_CYCLES  (3)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .btn_raw   (btn_raw),
    .sw_states (sw_states),
    .btn_edit  (btn_edit),
    .btn_level (btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no summary, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // One clock: returns just after the next falling edge (inputs driven / outputs sampled here).
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Expected btn_edit[1] after edge e for a hold starting at edge 0 and released at edge 60.
  function automatic logic rpt_exp(input int e);
    int starts[6] = '{6, 26, 34, 42, 50, 58};
    rpt_exp = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (e >= starts[k] && e <= starts[k] + 2) rpt_exp = 1'b1;
    end
  endfunction

  initial begin
    int rises;
    int highs;
    logic prev;
    logic [4:0] bounce;

    reset   = 1'b0;
    sw_raw  = 3'b000;
    btn_raw = 2'b11;
    @(negedge clk);
    steps(3);
    check("rst_sw", 32'(sw_states), 32'h0);
    check("rst_edit", 32'(btn_edit), 32'h0);
    check("rst_level", 32'(btn_level), 32'h0);

    // Idle after reset release
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      steps(1);
      check("idle_outs", {25'd0, sw_states, btn_edit, btn_level}, 32'h0);
    end

    // Clean switch step: visible after edge 6, not after edge 5
    sw_raw = 3'b101;
    steps(6);
    check("sw_early", 32'(sw_states), 32'h0);
    steps(1);
    check("sw_step", 32'(sw_states), 32'h5);

    // 3-cycle glitch on sw_raw[1]
    sw_raw = 3'b111;
    steps(3);
    sw_raw = 3'b101;
    for (int i = 0; i < 12; i++) begin
      steps(1);
      check("sw_glitch", 32'(sw_states), 32'h5);
    end

    // Clean 10-cycle press of button 0
    btn_raw = 2'b10;
    steps(6);
    check("b0_lvl_early", 32'(btn_level), 32'h0);
    check("b0_edit_early", 32'(btn_edit), 32'h0);
    steps(1);
    check("b0_lvl_rise", 32'(btn_level), 32'h1);
    check("b0_edit_e6", 32'(btn_edit), 32'h1);
    steps(1);
    check("b0_edit_e7", 32'(btn_edit), 32'h1);
    steps(1);
    check("b0_edit_e8", 32'(btn_edit), 32'h1);
    steps(1);
    check("b0_edit_e9", 32'(btn_edit), 32'h0);
    btn_raw = 2'b11;
    steps(6);
    check("b0_lvl_hold", 32'(btn_level), 32'h1);
    check("b0_rel_edit_a", 32'(btn_edit), 32'h0);
    steps(1);
    check("b0_lvl_fall", 32'(btn_level), 32'h0);
    check("b0_rel_edit_b", 32'(btn_edit), 32'h0);
    steps(5);

    // Bouncy press with a mid-press blip: one event, three cycles
    bounce = 5'b01010;
    rises  = 0;
    highs  = 0;
    prev   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c < 5) btn_raw[0] = bounce[4 - c];
      else if (c == 12) btn_raw[0] = 1'b1;
      else if (c < 20) btn_raw[0] = 1'b0;
      else btn_raw[0] = 1'b1;
      steps(1);
      if (btn_edit[0]) highs++;
      if (btn_edit[0] && !prev) rises++;
      prev = btn_edit[0];
    end
    check("bounce_rises", 32'(rises), 32'd1);
    check("bounce_highs", 32'(highs), 32'd3);
    check("bounce_lvl_end", 32'(btn_level), 32'h0);

    // Hold button 1 for 60 cycles: initial, +20, then every 8
    btn_raw = 2'b01;
    for (int e = 0; e < 80; e++) begin
      if (e == 60) btn_raw = 2'b11;
      steps(1);
      check("rpt_edit", 32'(btn_edit), {30'd0, rpt_exp(e), 1'b0});
    end
    steps(10);

    // Simultaneous presses
    btn_raw = 2'b00;
    steps(6);
    check("both_early", 32'(btn_edit), 32'h0);
    for (int i = 0; i < 3; i++) begin
      steps(1);
      check("both_edit", 32'(btn_edit), 32'h3);
    end
    steps(1);
    check("both_end", 32'(btn_edit), 32'h0);
    btn_raw = 2'b11;
    steps(20);

    // Reset during a repeat stretch, then fresh event with button still held
    btn_raw = 2'b01;
    steps(27);
    check("pre_rst_rpt", 32'(btn_edit), 32'h2);
    reset = 1'b0;
    steps(1);
    check("midrst_edit", 32'(btn_edit), 32'h0);
    check("midrst_level", 32'(btn_level), 32'h0);
    check("midrst_sw", 32'(sw_states), 32'h0);
    reset = 1'b1;
    steps(6);
    check("post_rst_early", 32'(btn_edit), 32'h0);
    check("post_rst_sw_early", 32'(sw_states), 32'h0);
    steps(1);
    check("post_rst_edit", 32'(btn_edit), 32'h2);
    check("post_rst_level", 32'(btn_level), 32'h2);
    check("post_rst_sw", 32'(sw_states), 32'h5);
    steps(2);
    check("post_rst_edit_e8", 32'(btn_edit), 32'h2);
    steps(1);
    check("post_rst_edit_e9", 32'(btn_edit), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
